// File: rtl/decode_pkg.sv
// Shared types and code points for the SECDED decode controller.
package decode_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    FIX,
    DONE
  } state_t;

  localparam logic [1:0] MODE_SMALL   = 2'b00;
  localparam logic [1:0] MODE_MEDIUM  = 2'b01;
  localparam logic [1:0] MODE_LARGE   = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam logic [1:0] NOF_NONE   = 2'b00;
  localparam logic [1:0] NOF_SINGLE = 2'b10;
  localparam logic [1:0] NOF_DOUBLE = 2'b01;

  localparam logic [1:0] ST_CLEAN   = 2'b00;
  localparam logic [1:0] ST_FIXED   = 2'b10;
  localparam logic [1:0] ST_DOUBLE  = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  function automatic logic [31:0] flip_bit(input logic [31:0] word, input logic [4:0] idx);
    return word ^ (32'h1 << idx);
  endfunction

endpackage

// File: rtl/decode_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/decode_ctrl.sv
// Sequences one codeword through the external syndrome datapath, corrects single
// errors and returns data/status over valid/ready, with error statistics.
module decode_ctrl
  import decode_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [4:0]       in_yin,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_status,
  output logic [31:0]      syn_data,
  output logic [4:0]       syn_yin,
  output logic             syn_small,
  output logic             syn_medium,
  input  logic [1:0]       syn_nof,
  input  logic [4:0]       syn_noe,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double
);

  state_t      state, state_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  yin_q, yin_d;
  logic [1:0]  mode_q, mode_d;
  logic [4:0]  noe_q, noe_d;
  logic [31:0] out_data_d;
  logic [1:0]  out_status_d;
  logic        inc_single, inc_double;

  always_comb begin
    state_d      = state;
    data_d       = data_q;
    yin_d        = yin_q;
    mode_d       = mode_q;
    noe_d        = noe_q;
    out_data_d   = out_data;
    out_status_d = out_status;
    inc_single   = 1'b0;
    inc_double   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          yin_d  = in_yin;
          mode_d = in_mode;
          if (in_mode == MODE_ILLEGAL) begin
            out_data_d   = in_data;
            out_status_d = ST_ILLEGAL;
            state_d      = DONE;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        // The fault count steers the branch directly; only the index is needed later.
        noe_d = syn_noe;
        case (syn_nof)
          NOF_NONE: begin
            out_data_d   = data_q;
            out_status_d = ST_CLEAN;
            state_d      = DONE;
          end
          NOF_SINGLE: begin
            state_d = FIX;
          end
          default: begin
            out_data_d   = data_q;
            out_status_d = ST_DOUBLE;
            inc_double   = 1'b1;
            state_d      = DONE;
          end
        endcase
      end
      FIX: begin
        out_data_d   = flip_bit(data_q, noe_q);
        out_status_d = ST_FIXED;
        inc_single   = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stored mode resets to LARGE so both size decodes read low out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_q     <= '0;
      yin_q      <= '0;
      mode_q     <= MODE_LARGE;
      noe_q      <= '0;
      out_data   <= '0;
      out_status <= ST_CLEAN;
    end else begin
      state      <= state_d;
      data_q     <= data_d;
      yin_q      <= yin_d;
      mode_q     <= mode_d;
      noe_q      <= noe_d;
      out_data   <= out_data_d;
      out_status <= out_status_d;
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign syn_data   = data_q;
  assign syn_yin    = yin_q;
  assign syn_small  = (mode_q == MODE_SMALL);
  assign syn_medium = (mode_q == MODE_MEDIUM);

  sat_counter #(.CNT_W(CNT_W)) u_cnt_single (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (inc_single),
    .count (cnt_single)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_double (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (inc_double),
    .count (cnt_double)
  );

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: acts as the syndrome datapath and checks every cycle
// against a transaction-level model of the controller's outcome and latency.
module tb_decode_ctrl;
  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic [4:0]       in_yin = '0;
  logic [1:0]       in_mode = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [1:0]       out_status;
  logic [31:0]      syn_data;
  logic [4:0]       syn_yin;
  logic             syn_small, syn_medium;
  logic [1:0]       syn_nof = '0;
  logic [4:0]       syn_noe = '0;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] cnt_single, cnt_double;

  always #5 clk = ~clk;

  decode_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_yin     (in_yin),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status),
    .syn_data   (syn_data),
    .syn_yin    (syn_yin),
    .syn_small  (syn_small),
    .syn_medium (syn_medium),
    .syn_nof    (syn_nof),
    .syn_noe    (syn_noe),
    .clr_cnt    (clr_cnt),
    .cnt_single (cnt_single),
    .cnt_double (cnt_double)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // model of the transaction in flight and the stored datapath inputs
  bit          m_busy = 1'b0;
  int          m_done = 0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_status = '0;
  int          m_ev_s = 0, m_ev_d = 0, m_base_s = 0, m_base_d = 0;
  logic [31:0] m_sdata = '0;
  logic [4:0]  m_syin = '0;
  logic [1:0]  m_mode = 2'b10;
  logic [31:0] last_data;
  logic [1:0]  last_status;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      bit v;
      v = m_busy && (cyc >= m_done);
      check("in_ready", 32'(in_ready), 32'(!m_busy));
      check("out_valid", 32'(out_valid), 32'(v));
      if (v) begin
        check("out_data", out_data, m_data);
        check("out_status", 32'(out_status), 32'(m_status));
      end
      check("cnt_single", 32'(cnt_single), 32'(sat(m_base_s + (v ? m_ev_s : 0))));
      check("cnt_double", 32'(cnt_double), 32'(sat(m_base_d + (v ? m_ev_d : 0))));
      check("syn_data", syn_data, m_sdata);
      check("syn_yin", 32'(syn_yin), 32'(m_syin));
      check("syn_small", 32'(syn_small), 32'(m_mode == 2'b00));
      check("syn_medium", 32'(syn_medium), 32'(m_mode == 2'b01));
    end
  end

  task automatic set_model(input logic [31:0] d, input logic [4:0] y, input logic [1:0] mode,
                           input logic [1:0] nof, input logic [4:0] noe);
    int lat;
    m_busy = 1'b1; m_sdata = d; m_syin = y; m_mode = mode;
    m_ev_s = 0; m_ev_d = 0; m_data = d;
    if (mode == 2'b11) begin
      m_status = 2'b11; lat = 1;
    end else if (nof == 2'b00) begin
      m_status = 2'b00; lat = 2;
    end else if (nof == 2'b10) begin
      m_status = 2'b10; m_data = d ^ (32'h1 << noe); lat = 3; m_ev_s = 1;
    end else begin
      m_status = 2'b01; lat = 2; m_ev_d = 1;
    end
    // cyc already counts the accepting edge, so first valid cycle T+lat is cyc+lat-1
    m_done = cyc + lat - 1;
  endtask

  task automatic xact(input logic [31:0] d, input logic [4:0] y, input logic [1:0] mode,
                      input logic [1:0] nof, input logic [4:0] noe, input int hold, input bit clr_fix);
    bit found;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_yin = y; in_mode = mode;
    syn_nof = nof; syn_noe = noe; out_ready = (hold == 0);
    @(posedge clk); #1;
    set_model(d, y, mode, nof, noe);
    if (hold > 0) begin
      in_data = ~d; in_yin = ~y; in_mode = 2'b00;
    end else begin
      in_valid = 1'b0;
    end
    if (clr_fix) begin
      @(negedge clk);
      @(negedge clk);
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      m_base_s = 0; m_base_d = 0; m_ev_s = 0; m_ev_d = 0;
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (out_valid && out_ready) found = 1'b1;
      else @(negedge clk);
    end
    check("handshake_timeout", 32'(found), 32'd1);
    last_data = out_data;
    last_status = out_status;
    if (found) begin
      @(posedge clk); #1;
      m_base_s = sat(m_base_s + m_ev_s);
      m_base_d = sat(m_base_d + m_ev_d);
      m_busy = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_status", 32'(out_status), 32'd0);
    check("rst_syn_data", syn_data, 32'd0);
    check("rst_syn_yin", 32'(syn_yin), 32'd0);
    check("rst_syn_small", 32'(syn_small), 32'd0);
    check("rst_syn_medium", 32'(syn_medium), 32'd0);
    check("rst_cnt_single", 32'(cnt_single), 32'd0);
    check("rst_cnt_double", 32'(cnt_double), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    xact(32'h0000_00A5, 5'h0C, 2'b10, 2'b00, 5'd0, 0, 1'b0);
    check("t1_data", last_data, 32'h0000_00A5);
    check("t1_status", 32'(last_status), 32'd0);
    check("t1_cnt", 32'({cnt_single, cnt_double}), 32'd0);

    xact(32'h0001_0080, 5'h11, 2'b01, 2'b10, 5'd7, 0, 1'b0);
    check("t2_data", last_data, 32'h0001_0000);
    check("t2_status", 32'(last_status), 32'd2);
    check("t2_cnt_single", 32'(cnt_single), 32'd1);

    xact(32'hDEAD_BEEF, 5'h1F, 2'b00, 2'b01, 5'd4, 0, 1'b0);
    check("t3_data", last_data, 32'hDEAD_BEEF);
    check("t3_status", 32'(last_status), 32'd1);
    check("t3_cnt_double", 32'(cnt_double), 32'd1);
    check("t3_syn_small", 32'(syn_small), 32'd1);
    check("t3_syn_medium", 32'(syn_medium), 32'd0);

    xact(32'h5555_AAAA, 5'h03, 2'b11, 2'b10, 5'd1, 10, 1'b0);
    check("t4_data", last_data, 32'h5555_AAAA);
    check("t4_status", 32'(last_status), 32'd3);
    check("t4_cnt_single", 32'(cnt_single), 32'd1);
    check("t4_cnt_double", 32'(cnt_double), 32'd1);

    for (int i = 0; i < 17; i++)
      xact(32'h1000_0000 + 32'(i), 5'(i), 2'b10, 2'b10, 5'(i * 3), 0, 1'b0);
    check("sat_cnt_single", 32'(cnt_single), 32'd15);

    xact(32'h0000_0001, 5'h00, 2'b10, 2'b10, 5'd0, 0, 1'b1);
    check("clr_data", last_data, 32'h0000_0000);
    check("clr_cnt_single", 32'(cnt_single), 32'd0);
    check("clr_cnt_double", 32'(cnt_double), 32'd0);

    xact(32'h8000_0000, 5'h02, 2'b00, 2'b10, 5'd31, 0, 1'b0);
    check("pre_rst_data", last_data, 32'h0000_0000);
    check("pre_rst_cnt_single", 32'(cnt_single), 32'd1);

    // reset asserted while the controller sits in FIX
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h0000_F00F; in_yin = 5'h05; in_mode = 2'b01;
    syn_nof = 2'b10; syn_noe = 5'd3; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    set_model(32'h0000_F00F, 5'h05, 2'b01, 2'b10, 5'd3);
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_out_status", 32'(out_status), 32'd0);
    check("mid_rst_syn_data", syn_data, 32'd0);
    check("mid_rst_syn_medium", 32'(syn_medium), 32'd0);
    check("mid_rst_cnt_single", 32'(cnt_single), 32'd0);
    m_busy = 1'b0; m_base_s = 0; m_base_d = 0; m_ev_s = 0; m_ev_d = 0;
    m_sdata = '0; m_syin = '0; m_mode = 2'b10;
    @(posedge clk); #1;
    check("held_rst_cnt_single", 32'(cnt_single), 32'd0);
    check("held_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    xact(32'h1234_5678, 5'h0A, 2'b10, 2'b00, 5'd0, 0, 1'b0);
    check("post_rst_data", last_data, 32'h1234_5678);
    check("post_rst_status", 32'(last_status), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
